apb_uart_csr: RTL

// APB3 completer (slave) for the UART register bank; the responder end of the APB bus our TB drives.

---
 rtl/apb_uart_csr.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/apb_uart_csr.sv
// APB3 completer for the UART register bank: TX FIFO, RX holding register, CTRL/STATUS CSRs.
// Programmable access-phase wait states; bad accesses are answered with PSLVERR and no side effect.
module apb_uart_csr #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_STATES = 0,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              PSELx,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [15:0]       baud_div,
    output logic              tx_en,
    output logic              rx_en
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [1:0] A_TX = 2'd0, A_RX = 2'd1, A_STATUS = 2'd2, A_CTRL = 2'd3;

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t            state_reg, state_next;
    logic [3:0]        wait_reg, wait_next;
    logic              ready;

    logic [7:0]        fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [PTR_W:0]    count_reg, count_next;
    logic              tx_full, tx_empty, push, pop;

    logic [7:0]        rx_byte_reg;
    logic              rx_full_reg, overrun_reg;
    logic              rx_pop, status_rd;
    logic [17:0]       ctrl_reg;

    logic [1:0]        reg_sel;
    logic              addr_ok, err, complete, wr_ok, rd_ok;
    logic [DATA_W-1:0] rdata;
    logic [31:0]       count_ext;
    logic [3:0]        tx_count;
    logic              unused_pwdata;

    assign unused_pwdata = ^PWDATA[DATA_W-1:18];

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_reg <= IDLE;
            wait_reg  <= '0;
        end else begin
            state_reg <= state_next;
            wait_reg  <= wait_next;
        end
    end

    // A fresh setup phase seen while in ACCESS restarts the wait count.
    always_comb begin
        state_next = state_reg;
        wait_next  = wait_reg;
        ready      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (PSELx && !PENABLE) begin
                    state_next = ACCESS;
                    wait_next  = 4'(WAIT_STATES);
                end
            end
            ACCESS: begin
                if (!PSELx) begin
                    state_next = IDLE;
                end else if (!PENABLE) begin
                    wait_next = 4'(WAIT_STATES);
                end else if (wait_reg != 4'd0) begin
                    wait_next = wait_reg - 4'd1;
                end else begin
                    ready      = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign tx_full   = (count_reg == DEPTH_C);
    assign tx_empty  = (count_reg == '0);
    assign count_ext = 32'(count_reg);
    assign tx_count  = (count_ext > 32'd15) ? 4'hF : count_ext[3:0];

    assign reg_sel  = PADDR[3:2];
    assign addr_ok  = (PADDR[1:0] == 2'b00) && (PADDR[ADDR_W-1:4] == '0);
    assign complete = PSELx && PENABLE && ready;

    always_comb begin
        err = !addr_ok;
        if (PWRITE && (reg_sel == A_RX || reg_sel == A_STATUS))
            err = 1'b1;
        if (PWRITE && reg_sel == A_TX && tx_full)
            err = 1'b1;
        if (!PWRITE && reg_sel == A_RX && !rx_full_reg)
            err = 1'b1;
    end

    always_comb begin
        rdata = '0;
        case (reg_sel)
            A_TX:     rdata = '0;
            A_RX:     rdata = DATA_W'(rx_byte_reg);
            A_STATUS: rdata = DATA_W'({tx_count, overrun_reg, rx_full_reg, tx_empty, tx_full});
            A_CTRL:   rdata = DATA_W'(ctrl_reg);
            default:  rdata = '0;
        endcase
    end

    assign wr_ok     = complete && !err && PWRITE;
    assign rd_ok     = complete && !err && !PWRITE;
    assign push      = wr_ok && (reg_sel == A_TX);
    assign pop       = tx_valid && tx_ready;
    assign rx_pop    = rd_ok && (reg_sel == A_RX);
    assign status_rd = rd_ok && (reg_sel == A_STATUS);

    assign PREADY  = ready;
    assign PSLVERR = complete && err;
    assign PRDATA  = rd_ok ? rdata : '0;

    assign tx_valid = !tx_empty;
    assign tx_data  = tx_valid ? fifo_mem[rd_ptr_reg] : 8'h00;
    assign baud_div = ctrl_reg[15:0];
    assign tx_en    = ctrl_reg[16];
    assign rx_en    = ctrl_reg[17];

    always_comb begin
        count_next = count_reg;
        if (push && !pop)
            count_next = count_reg + 1'b1;
        else if (pop && !push)
            count_next = count_reg - 1'b1;
    end

    always_ff @(posedge PCLK) begin
        if (push)
            fifo_mem[wr_ptr_reg] <= PWDATA[7:0];
    end

    // Pointer widths equal log2(depth), so increments wrap naturally.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_next;
        end
    end

    // A byte arriving while the bus pops the old one replaces it without overrun;
    // an overrun on the same cycle as a STATUS read wins over the clear.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rx_byte_reg <= 8'h00;
            rx_full_reg <= 1'b0;
            overrun_reg <= 1'b0;
            ctrl_reg    <= '0;
        end else begin
            if (rx_valid && (!rx_full_reg || rx_pop)) begin
                rx_byte_reg <= rx_data;
                rx_full_reg <= 1'b1;
            end else if (rx_pop) begin
                rx_full_reg <= 1'b0;
            end
            if (rx_valid && rx_full_reg && !rx_pop)
                overrun_reg <= 1'b1;
            else if (status_rd)
                overrun_reg <= 1'b0;
            if (wr_ok && reg_sel == A_CTRL)
                ctrl_reg <= PWDATA[17:0];
        end
    end
endmodule
